// File: rtl/pulse_meter_pkg.sv
// Shared types and constants for the pulse meter: FSM states, datapath widths
// and the four selectable gate lengths.
package pulse_meter_pkg;

  localparam int COUNT_W    = 8;
  localparam int WIN_W      = 14;
  localparam int GATE_LEN_0 = 256;
  localparam int GATE_LEN_1 = 1024;
  localparam int GATE_LEN_2 = 4096;
  localparam int GATE_LEN_3 = 16384;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_t;

  // Terminal value of the window counter; GATE_LEN_3 itself does not fit in WIN_W bits.
  function automatic logic [WIN_W-1:0] gate_last(input logic [1:0] sel);
    logic [WIN_W-1:0] w_last;
    case (sel)
      2'd0:    w_last = WIN_W'(GATE_LEN_0 - 1);
      2'd1:    w_last = WIN_W'(GATE_LEN_1 - 1);
      2'd2:    w_last = WIN_W'(GATE_LEN_2 - 1);
      default: w_last = WIN_W'(GATE_LEN_3 - 1);
    endcase
    return w_last;
  endfunction

endpackage

// File: rtl/pulse_meter_sync.sv
// sig_in conditioning: 2-flop synchronizer, optional 3-sample debounce
// (PULSE_METER_DEBOUNCE_EN), and a registered rising-edge detector.
module pulse_meter_sync
  import pulse_meter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_evt
);

  logic r_meta;
  logic r_sync;
  logic r_lvl;
  logic r_prev;
  logic r_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_sig;
      r_sync <= r_meta;
    end
  end

`ifdef PULSE_METER_DEBOUNCE_EN
  logic r_h1;
  logic r_h2;

  // Level follows only after three identical synchronized samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h1  <= 1'b0;
      r_h2  <= 1'b0;
      r_lvl <= 1'b0;
    end else begin
      r_h1 <= r_sync;
      r_h2 <= r_h1;
      if ((r_sync == r_h1) && (r_h1 == r_h2)) begin
        r_lvl <= r_h2;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lvl <= 1'b0;
    end else begin
      r_lvl <= r_sync;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
      r_evt  <= 1'b0;
    end else begin
      r_prev <= r_lvl;
      r_evt  <= r_lvl & ~r_prev;
    end
  end

  assign o_evt = r_evt;

endmodule

// File: rtl/pulse_meter.sv
// Gated event counter: counts sig_in rising edges over a selectable window and
// publishes a saturating 8-bit count. Optional filter: PULSE_METER_DEBOUNCE_EN.
module pulse_meter
  import pulse_meter_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sig_in,
  input  logic                start,
  input  logic [1:0]          gate_sel,
  output logic [COUNT_W-1:0]  count_out,
  output logic                busy,
  output logic                done,
  output logic                overflow
);

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_sel;
  logic [WIN_W-1:0]     r_win;
  logic [COUNT_W-1:0]   r_acc;
  logic                 r_sat;
  logic [COUNT_W-1:0]   r_count;
  logic                 r_ovf;
  logic                 w_evt;
  logic                 w_last;
  logic [COUNT_W-1:0]   w_acc_next;
  logic                 w_sat_next;

  pulse_meter_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_sig (sig_in),
    .o_evt (w_evt)
  );

  assign w_last = (r_win == gate_last(r_sel));

  always_comb begin
    w_acc_next = r_acc;
    w_sat_next = r_sat;
    if (w_evt) begin
      if (r_acc == {COUNT_W{1'b1}}) begin
        w_sat_next = 1'b1;
      end else begin
        w_acc_next = r_acc + 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = GATE;
      GATE:    if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The final gate cycle's event is folded in via w_acc_next when publishing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel   <= 2'd0;
      r_win   <= '0;
      r_acc   <= '0;
      r_sat   <= 1'b0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sel <= gate_sel;
            r_win <= '0;
            r_acc <= '0;
            r_sat <= 1'b0;
          end
        end
        GATE: begin
          r_acc <= w_acc_next;
          r_sat <= w_sat_next;
          r_win <= r_win + 1'b1;
          if (w_last) begin
            r_count <= w_acc_next;
            r_ovf   <= w_sat_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign count_out = r_count;
  assign overflow  = r_ovf;
  assign busy      = (r_state == GATE);
  assign done      = (r_state == DONE);

endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter: scoreboard of expected results per run,
// compared when the done pulse appears.
module tb_pulse_meter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sig_in = 1'b0;
  logic       start = 1'b0;
  logic [1:0] gate_sel = 2'd0;
  logic [7:0] count_out;
  logic       busy;
  logic       done;
  logic       overflow;

  int checks = 0;
  int failures = 0;

  int sig_mode = 1;
  int sig_per = 2;
  int phase = 0;

  logic [7:0] snap_cnt;
  logic       snap_ovf;

  typedef struct {
    logic [7:0] cnt;
    logic       ovf;
  } exp_t;
  exp_t sb[$];

`ifdef PULSE_METER_DEBOUNCE_EN
  localparam logic [7:0] EXP_P2_CNT = 8'd0;
  localparam logic       EXP_P2_OVF = 1'b0;
  localparam logic [7:0] EXP_GLITCH = 8'd0;
`else
  localparam logic [7:0] EXP_P2_CNT = 8'd255;
  localparam logic       EXP_P2_OVF = 1'b1;
  localparam logic [7:0] EXP_GLITCH = 8'd16;
`endif

  pulse_meter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .start     (start),
    .gate_sel  (gate_sel),
    .count_out (count_out),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // sig_in pattern generator: 0 = low, 1 = square wave of sig_per, 2 = 1-cycle glitch every 16
  initial begin
    forever begin
      @(negedge clk);
      phase = phase + 1;
      case (sig_mode)
        1:       sig_in = ((phase % sig_per) < (sig_per / 2));
        2:       sig_in = ((phase % 16) == 0);
        default: sig_in = 1'b0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_sig(input int mode, input int per);
    sig_mode = mode;
    sig_per  = per;
    repeat (24) @(negedge clk);
  endtask

  task automatic begin_run(input logic [1:0] sel, input logic [7:0] ecnt, input logic eovf);
    exp_t e;
    e.cnt = ecnt;
    e.ovf = eovf;
    sb.push_back(e);
    snap_cnt = count_out;
    snap_ovf = overflow;
    gate_sel = sel;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    gate_sel = 2'($urandom);
  endtask

  task automatic finish_run(input string tag, input int elen, input bit extra, input bit hold);
    int   n;
    bit   stable;
    bit   seen;
    exp_t e;
    n = 0;
    stable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (!busy) begin
        seen = 1'b1;
        break;
      end
      n++;
      if ((count_out !== snap_cnt) || (overflow !== snap_ovf) || (done !== 1'b0)) stable = 1'b0;
      if (extra) begin
        start    = ((n == 10) || (n == 200));
        gate_sel = 2'd3;
      end
    end
    start = 1'b0;
    check({tag, "_gate_ended"}, 32'(seen), 32'd1);
    check({tag, "_busy_len"}, n, elen);
    check({tag, "_held_in_gate"}, 32'(stable), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_count"}, 32'(count_out), 32'(e.cnt));
      check({tag, "_ovf"}, 32'(overflow), 32'(e.ovf));
    end
    if (hold) start = 1'b1;
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset held with sig_in toggling
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_count", 32'(count_out), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
    end
    rst_n = 1'b1;

    set_sig(1, 8);
    begin_run(2'd0, 8'd32, 1'b0);
    finish_run("p8_sel0", 256, 1'b0, 1'b0);

    set_sig(1, 2);
    begin_run(2'd1, EXP_P2_CNT, EXP_P2_OVF);
    finish_run("p2_sel1", 1024, 1'b0, 1'b0);

    set_sig(0, 8);
    begin_run(2'd0, 8'd0, 1'b0);
    finish_run("quiet_sel0", 256, 1'b0, 1'b0);

    // Restart pulses inside the window are ignored; start held into DONE restarts from IDLE
    set_sig(1, 8);
    begin_run(2'd0, 8'd32, 1'b0);
    finish_run("restart_ignored", 256, 1'b1, 1'b1);
    begin_run(2'd0, 8'd32, 1'b0);
    finish_run("held_start", 256, 1'b0, 1'b0);

    // Reset in the middle of a long window
    begin_run(2'd2, 8'd0, 1'b0);
    repeat (100) @(negedge clk);
    check("mid_busy_before_rst", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_count", 32'(count_out), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_no_done", 32'(done), 32'd0);
    check("post_rst_idle", 32'(busy), 32'd0);

    begin_run(2'd0, 8'd32, 1'b0);
    finish_run("post_rst_p8", 256, 1'b0, 1'b0);

    set_sig(2, 16);
    begin_run(2'd0, EXP_GLITCH, 1'b0);
    finish_run("glitch", 256, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
